// File: rtl/bsg_credit_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bsg_credit_rr_scheduler
// Description : Round-robin grant of a shared credit pool among els_p
//               requesters, with a drain/resume handshake that parks the
//               scheduler until every credit has come home, and a sticky
//               overflow flag for credits returned into a full pool.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_credit_rr_scheduler #(
    parameter int els_p         = 4,
    parameter int max_credits_p = 8,
    localparam int cw           = $clog2(max_credits_p + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [els_p-1:0] v_i,
    output logic [els_p-1:0] yumi_o,
    input  logic             credit_return_i,
    input  logic             drain_i,
    input  logic             resume_i,
    output logic [cw-1:0]    credits_o,
    output logic             drained_o,
    output logic             overflow_o
);

    localparam int            c_LW       = $clog2(els_p);
    localparam logic [cw-1:0] c_MAX      = cw'(max_credits_p);
    localparam logic [c_LW-1:0] c_LAST_RST = c_LW'(els_p - 1);
    localparam logic [c_LW:0] c_ELS      = (c_LW + 1)'(els_p);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DRAIN   = 2'd1,
        S_DRAINED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [cw-1:0]     r_credits;
    logic [cw-1:0]     w_credits_next;
    logic [c_LW-1:0]   r_last;
    logic              r_overflow;
    logic              w_overflow_set;
    logic [els_p-1:0]  w_pick;
    logic [c_LW-1:0]   w_pick_idx;
    logic [c_LW:0]     w_idx;
    logic              w_found;
    logic              w_grant_ok;
    logic              w_grant;

    // A grant is allowed only from registered state and the non-credit inputs;
    // credit_return_i never feeds this term, so a returned credit cannot bypass.
    assign w_grant_ok = !reset_i && (r_state == S_RUN) && !drain_i
                        && (r_credits != '0);
    assign w_grant    = w_grant_ok && w_found;

    // Round-robin search: scan from last winner + 1, wrapping at els_p.
    always_comb begin
        w_pick     = '0;
        w_pick_idx = r_last;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int i = 1; i <= els_p; i++) begin
            w_idx = {1'b0, r_last} + (c_LW + 1)'(i);
            if (w_idx >= c_ELS) begin
                w_idx = w_idx - c_ELS;
            end
            if (!w_found && v_i[w_idx[c_LW-1:0]]) begin
                w_found    = 1'b1;
                w_pick_idx = w_idx[c_LW-1:0];
            end
        end
        if (w_found) begin
            w_pick[w_pick_idx] = 1'b1;
        end
    end

    // Next credit count: +return -grant, saturating at the pool size.
    always_comb begin
        w_credits_next = r_credits;
        w_overflow_set = 1'b0;
        if (credit_return_i && !w_grant) begin
            if (r_credits == c_MAX) begin
                w_overflow_set = 1'b1;
            end else begin
                w_credits_next = r_credits + cw'(1);
            end
        end else if (!credit_return_i && w_grant) begin
            w_credits_next = r_credits - cw'(1);
        end
    end

    // Drain handshake state transitions.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:     if (drain_i) w_state_next = S_DRAIN;
            S_DRAIN:   if (w_credits_next == c_MAX) w_state_next = S_DRAINED;
            S_DRAINED: if (resume_i) w_state_next = S_RUN;
            default:   w_state_next = S_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Credit counter, round-robin pointer and sticky overflow registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_credits  <= c_MAX;
            r_last     <= c_LAST_RST;
            r_overflow <= 1'b0;
        end else begin
            r_credits <= w_credits_next;
            if (w_grant) begin
                r_last <= w_pick_idx;
            end
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign yumi_o     = w_grant_ok ? w_pick : '0;
    assign credits_o  = r_credits;
    assign drained_o  = (r_state == S_DRAINED);
    assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bsg_credit_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsg_credit_rr_scheduler
// Description : Directed vector table plus randomized run against a
//               behavioural model of the credit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_credit_rr_scheduler;

    localparam int c_ELS = 4;
    localparam int c_MAX = 8;
    localparam int c_CW  = 4;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [c_ELS-1:0] v_i;
    logic [c_ELS-1:0] yumi_o;
    logic             credit_return_i;
    logic             drain_i;
    logic             resume_i;
    logic [c_CW-1:0]  credits_o;
    logic             drained_o;
    logic             overflow_o;

    int errors = 0;
    int checks = 0;

    bsg_credit_rr_scheduler #(.els_p(c_ELS), .max_credits_p(c_MAX)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .v_i            (v_i),
        .yumi_o         (yumi_o),
        .credit_return_i(credit_return_i),
        .drain_i        (drain_i),
        .resume_i       (resume_i),
        .credits_o      (credits_o),
        .drained_o      (drained_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       ret;
        logic       drn;
        logic       res;
        logic [3:0] e_yumi;
        int         e_cred;
        logic       e_drained;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] v, logic ret, logic drn,
                                logic res, logic [3:0] ey, int ec, logic ed,
                                logic eo);
        vec_t r;
        r.rst = rst; r.v = v; r.ret = ret; r.drn = drn; r.res = res;
        r.e_yumi = ey; r.e_cred = ec; r.e_drained = ed; r.e_ovf = eo;
        return r;
    endfunction

    task automatic check(string name, int idx, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(int idx, logic [3:0] ey, int ec, logic ed, logic eo);
        check("yumi", idx, int'(yumi_o), int'(ey));
        check("credits", idx, int'(credits_o), ec);
        check("drained", idx, int'(drained_o), int'(ed));
        check("overflow", idx, int'(overflow_o), int'(eo));
    endtask

    // Behavioural model state
    int         m_cred;
    int         m_last;
    int         m_st;      // 0 run, 1 drain, 2 drained
    logic       m_ovf;

    function automatic logic [3:0] model_yumi(logic rst, logic [3:0] v, logic drn);
        logic [3:0] y = 4'b0000;
        if (!rst && m_st == 0 && !drn && m_cred > 0) begin
            for (int k = 1; k <= c_ELS; k++) begin
                int j = (m_last + k) % c_ELS;
                if (v[j] && y == 4'b0000) y[j] = 1'b1;
            end
        end
        return y;
    endfunction

    task automatic model_step(logic rst, logic [3:0] v, logic ret, logic drn, logic res);
        logic [3:0] y;
        int nxt;
        y = model_yumi(rst, v, drn);
        if (rst) begin
            m_cred = c_MAX; m_last = c_ELS - 1; m_st = 0; m_ovf = 1'b0;
        end else begin
            nxt = m_cred + int'(ret) - ((y != 0) ? 1 : 0);
            if (nxt > c_MAX) begin
                nxt = c_MAX;
                m_ovf = 1'b1;
            end
            for (int k = 0; k < c_ELS; k++) if (y[k]) m_last = k;
            case (m_st)
                0: if (drn) m_st = 1;
                1: if (nxt == c_MAX) m_st = 2;
                default: if (res) m_st = 0;
            endcase
            m_cred = nxt;
        end
    endtask

    initial begin
        // rst, v, ret, drn, res | yumi, cred, drained, ovf
        tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 4'b0000, 8, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0001, 8, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0010, 7, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0100, 6, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b1000, 5, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0001, 4, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0010, 3, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0100, 2, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b1000, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 0));
        // return at zero: no bypass
        tbl.push_back(mk(0, 4'b0100, 1, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0100, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 2, 0, 0));
        // grant + return holds count
        tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 4'b0001, 3, 0, 0));
        tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 4'b0001, 3, 0, 0));
        tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 4'b0001, 3, 0, 0));
        // drain, refill, drained, resume ignored early then honoured
        tbl.push_back(mk(0, 4'b1111, 0, 1, 0, 4'b0000, 3, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 1, 4'b0000, 3, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 4'b0000, 4, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 4'b0000, 5, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 4'b0000, 6, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 4'b0000, 7, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 1, 0, 4'b0000, 8, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 1, 4'b0000, 8, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0010, 8, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 4'b0100, 7, 0, 0));
        // overflow into full pool, sticky
        tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 7, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 8, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 8, 0, 1));
        tbl.push_back(mk(0, 4'b1000, 1, 0, 0, 4'b1000, 8, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 4'b0000, 8, 0, 1));
        // grant + return at full is legal, no overflow
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 4'b0001, 8, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 8, 0, 0));
        // drain while full still spends one cycle in DRAIN
        tbl.push_back(mk(0, 4'b0000, 0, 1, 0, 4'b0000, 8, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0000, 8, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 1, 0, 4'b0000, 8, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 4'b0000, 8, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 8, 0, 0));
        // reset mid-drain with credits outstanding
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0010, 8, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 1, 0, 4'b0000, 7, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 4'b0000, 7, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 8, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0001, 8, 0, 0));

        reset_i = 1'b1; v_i = '0; credit_return_i = 1'b0;
        drain_i = 1'b0; resume_i = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset_i = tbl[i].rst; v_i = tbl[i].v; credit_return_i = tbl[i].ret;
            drain_i = tbl[i].drn; resume_i = tbl[i].res;
            #1;
            check_all(i, tbl[i].e_yumi, tbl[i].e_cred, tbl[i].e_drained, tbl[i].e_ovf);
        end

        // Randomized run; first cycle is a reset so the model starts aligned.
        m_cred = 0; m_last = 0; m_st = 0; m_ovf = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic       r_rst, r_ret, r_drn, r_res;
            logic [3:0] r_v, ey;
            r_rst = (c == 0) || ($urandom_range(0, 63) == 0);
            r_v   = 4'($urandom_range(0, 15));
            r_ret = 1'($urandom_range(0, 1));
            r_drn = ($urandom_range(0, 15) == 0);
            r_res = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            reset_i = r_rst; v_i = r_v; credit_return_i = r_ret;
            drain_i = r_drn; resume_i = r_res;
            #1;
            if (c > 0) begin
                ey = model_yumi(r_rst, r_v, r_drn);
                check_all(1000 + c, ey, m_cred, (m_st == 2), m_ovf);
            end
            model_step(r_rst, r_v, r_ret, r_drn, r_res);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
